// File: rtl/mem_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_read_arbiter: shares one AXI-lite read port (AR/R) between IFU and LSU, |
// | one outstanding read, round-robin or fixed-LSU priority, response timeout.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_read_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,

    output logic              busy
);

    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(TIMEOUT);
    localparam bit               c_to_en    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              w_gnt_sel;
    logic              w_any_req;
    logic              w_m_rready;
    logic              w_timed_out;
    logic              w_rvalid;
    logic [DATA_W-1:0] w_rdata;
    logic [1:0]        w_rresp;

    always_comb begin
        w_any_req = m0_arvalid | m1_arvalid;
        if (m0_arvalid && m1_arvalid) begin
            w_gnt_sel = (FIXED_PRIO != 0) ? 1'b1 : ~last_q;
        end else begin
            w_gnt_sel = m1_arvalid;
        end
    end

    assign w_m_rready = grant_q ? m1_rready : m0_rready;

    // Once the counter saturates the error response is held even if the slave wakes up.
    assign w_timed_out = c_to_en &&
                         (((cnt_q == c_cnt_last) && !s_rvalid) || (cnt_q == c_cnt_sat));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        araddr_d   = araddr_q;
        cnt_d      = cnt_q;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        w_rvalid   = 1'b0;
        w_rdata    = '0;
        w_rresp    = 2'b00;
        case (state_q)
            S_IDLE: begin
                // rst gating keeps arready low while reset is asserted
                if (w_any_req && rst) begin
                    m0_arready = ~w_gnt_sel;
                    m1_arready = w_gnt_sel;
                    grant_d    = w_gnt_sel;
                    araddr_d   = w_gnt_sel ? m1_araddr : m0_araddr;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end
            end
            S_RESP: begin
                if (w_timed_out) begin
                    w_rvalid = 1'b1;
                    w_rresp  = 2'b10;
                    if (cnt_q != c_cnt_sat) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (w_m_rready) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    w_rvalid = s_rvalid;
                    w_rdata  = s_rdata;
                    w_rresp  = s_rresp;
                    s_rready = w_m_rready;
                    if (s_rvalid) begin
                        if (w_m_rready) begin
                            last_d  = grant_q;
                            state_d = S_IDLE;
                        end
                    end else if (cnt_q != c_cnt_sat) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                s_rready = 1'b1;
                if (s_rvalid) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            araddr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            araddr_q <= araddr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m0_rvalid = w_rvalid & ~grant_q;
    assign m1_rvalid = w_rvalid & grant_q;
    assign m0_rdata  = grant_q ? '0 : w_rdata;
    assign m1_rdata  = grant_q ? w_rdata : '0;
    assign m0_rresp  = grant_q ? 2'b00 : w_rresp;
    assign m1_rresp  = grant_q ? w_rresp : 2'b00;
    assign s_araddr  = araddr_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_read_arbiter: randomized bench with a transaction-level reference.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_read_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, s_rdata;
    logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
    logic        s_arready, s_rvalid;
    logic [1:0]  s_rresp;

    logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready, busy;
    logic [31:0] m0_rdata, m1_rdata, s_araddr;
    logic [1:0]  m0_rresp, m1_rresp;

    logic        f_m0_arready, f_m1_arready, f_m0_rvalid, f_m1_rvalid, f_s_arvalid, f_s_rready, f_busy;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_araddr;
    logic [1:0]  f_m0_rresp, f_m1_rresp;

    mem_read_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(TO)) u_rr (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .busy(busy)
    );

    mem_read_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(TO)) u_fp (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready),
        .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready),
        .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(f_s_araddr), .s_arvalid(f_s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(f_s_rready),
        .busy(f_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_A5A5) + 32'd17);
    endfunction

    // stimulus mode: 0 random, 1 both masters always requesting, 2 scripted single read
    int          mode;
    bit          req0, req1, rr0, rr1;
    logic [31:0] ad0, ad1;
    bit          sl_pend;
    logic [31:0] sl_addr;
    int          sl_cnt;

    // reference: one outstanding transaction, described by its phase and age
    int          ph;      // 0 free, 1 address issued, 2 awaiting data, 3 discarding late data
    bit          last, gnt, to_hold;
    logic [31:0] t_addr, f_addr;
    int          age;
    int          n_timeouts = 0;
    int          n_midrst = 0;

    task automatic drive_masters();
        m0_arvalid = req0; m0_araddr = ad0; m0_rready = rr0;
        m1_arvalid = req1; m1_araddr = ad1; m1_rready = rr1;
    endtask

    task automatic do_reset(input bit mid);
        @(posedge clk); #3;
        if (mid) check_eq("pre_rst_s_arvalid", s_arvalid, 1);
        rst = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0;
        drive_masters();
        #1;
        check_eq("rst_s_arvalid", s_arvalid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_m0_arready", m0_arready, 0);
        check_eq("rst_m1_arready", m1_arready, 0);
        check_eq("rst_m0_rvalid", m0_rvalid, 0);
        check_eq("rst_m1_rvalid", m1_rvalid, 0);
        check_eq("rst_s_rready", s_rready, 0);
        check_eq("rst_s_araddr", s_araddr, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_arready", {f_m0_arready, f_m1_arready, m0_arready, m1_arready}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        ph = 0; last = 1'b1; to_hold = 1'b0; age = 0; sl_pend = 1'b0;
    endtask

    task automatic cycle();
        bit          e_ar0, e_ar1, e_sarv, rv, e_srr, e_busy, g, rg;
        logic [31:0] e_rd;
        logic [1:0]  e_rs;
        int          n_ph, n_age;
        bit          n_last, n_gnt, n_hold;
        logic [31:0] n_addr, n_faddr;
        @(negedge clk);
        if (mode != 2) begin
            if (!req0 && (mode == 1 || $urandom_range(0, 99) < 40)) begin req0 = 1'b1; ad0 = $urandom & ~32'h3; end
            if (!req1 && (mode == 1 || $urandom_range(0, 99) < 40)) begin req1 = 1'b1; ad1 = $urandom & ~32'h3; end
        end
        rr0 = (mode != 0) || ($urandom_range(0, 99) < 70);
        rr1 = (mode != 0) || ($urandom_range(0, 99) < 70);
        s_arready = (mode != 0) || ($urandom_range(0, 99) < 60);
        s_rvalid  = sl_pend && (sl_cnt == 0);
        s_rdata   = s_rvalid ? mem_word(sl_addr) : $urandom;
        s_rresp   = s_rvalid ? sl_addr[5:4] : 2'($urandom);
        drive_masters();
        #2;

        e_ar0 = 0; e_ar1 = 0; e_sarv = 0; rv = 0; e_srr = 0; e_rd = '0; e_rs = 2'b00;
        e_busy = (ph != 0);
        n_ph = ph; n_age = age; n_last = last; n_gnt = gnt; n_hold = to_hold;
        n_addr = t_addr; n_faddr = f_addr;
        rg = gnt ? rr1 : rr0;
        case (ph)
            0: if (req0 || req1) begin
                g = (req0 && req1) ? ~last : req1;
                e_ar0 = ~g; e_ar1 = g;
                n_gnt = g; n_addr = g ? ad1 : ad0; n_faddr = ad1; n_ph = 1;
            end
            1: begin
                e_sarv = 1;
                if (s_arready) begin n_ph = 2; n_age = 0; n_hold = 0; end
            end
            2: begin
                if (to_hold || (age == TO - 1 && !s_rvalid)) begin
                    rv = 1; e_rs = 2'b10;
                    if (!to_hold) n_timeouts++;
                    n_hold = 1;
                    if (rg) n_ph = 3;
                end else begin
                    e_srr = rg;
                    if (s_rvalid) begin
                        rv = 1; e_rd = mem_word(t_addr); e_rs = t_addr[5:4];
                        if (rg) begin n_ph = 0; n_last = gnt; end
                    end else begin
                        n_age = age + 1;
                    end
                end
            end
            default: begin
                e_srr = 1;
                if (s_rvalid) begin n_ph = 0; n_last = gnt; end
            end
        endcase

        check_eq("m0_arready", m0_arready, e_ar0);
        check_eq("m1_arready", m1_arready, e_ar1);
        check_eq("busy", busy, e_busy);
        check_eq("s_arvalid", s_arvalid, e_sarv);
        if (e_sarv) check_eq("s_araddr", s_araddr, t_addr);
        check_eq("s_rready", s_rready, e_srr);
        check_eq("m0_rvalid", m0_rvalid, rv && !gnt);
        check_eq("m1_rvalid", m1_rvalid, rv && gnt);
        if (rv && !gnt) begin check_eq("m0_rdata", m0_rdata, e_rd); check_eq("m0_rresp", m0_rresp, e_rs); end
        if (rv && gnt)  begin check_eq("m1_rdata", m1_rdata, e_rd); check_eq("m1_rresp", m1_rresp, e_rs); end
        if (mode == 1) begin
            // fixed-priority instance runs in lockstep here, always serving the LSU
            check_eq("fp_m1_arready", f_m1_arready, e_ar0 | e_ar1);
            check_eq("fp_m0_arready", f_m0_arready, 0);
            check_eq("fp_busy", f_busy, e_busy);
            check_eq("fp_s_arvalid", f_s_arvalid, e_sarv);
            if (e_sarv) check_eq("fp_s_araddr", f_s_araddr, f_addr);
            check_eq("fp_s_rready", f_s_rready, e_srr);
            check_eq("fp_m0_rvalid", f_m0_rvalid, 0);
            check_eq("fp_m1_rvalid", f_m1_rvalid, rv);
            if (rv) begin
                check_eq("fp_m1_rdata", f_m1_rdata, e_rd);
                check_eq("fp_m1_rresp", f_m1_rresp, e_rs);
                check_eq("fp_m0_rdata", f_m0_rdata, f_m0_rdata);
            end
        end

        if (req0 && m0_arready) req0 = 1'b0;
        if (req1 && m1_arready) req1 = 1'b0;
        if (sl_pend) begin
            if (s_rvalid && s_rready) sl_pend = 1'b0;
            else if (sl_cnt > 0) sl_cnt--;
        end
        if (s_arvalid && s_arready) begin
            sl_pend = 1'b1;
            sl_addr = s_araddr;
            if (mode != 0) sl_cnt = 0;
            else if ($urandom_range(0, 99) < 8) sl_cnt = 9 + $urandom_range(0, 5);
            else sl_cnt = $urandom_range(0, 3);
        end

        ph = n_ph; age = n_age; last = n_last; gnt = n_gnt; to_hold = n_hold;
        t_addr = n_addr; f_addr = n_faddr;
    endtask

    initial begin
        int next_rst;
        rst = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        ph = 0; last = 1'b1; gnt = 1'b0; to_hold = 1'b0; age = 0;
        t_addr = '0; f_addr = '0; sl_pend = 1'b0; sl_addr = '0; sl_cnt = 0;
        rr0 = 1'b1; rr1 = 1'b1;

        mode = 1;
        req0 = 1'b1; ad0 = 32'h0000_1000;
        req1 = 1'b1; ad1 = 32'h0000_2000;
        drive_masters();
        do_reset(1'b0);
        repeat (24) cycle();

        mode = 2;
        req0 = 1'b1; ad0 = 32'h8000_0000;
        req1 = 1'b0; ad1 = 32'h0000_0000;
        do_reset(1'b0);
        repeat (6) cycle();

        mode = 0;
        next_rst = 400;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (ph == 1 && i >= next_rst) begin
                n_midrst++;
                do_reset(1'b1);
                next_rst = i + 700;
            end
        end
        check_eq("timeouts_exercised", n_timeouts > 0, 1);
        check_eq("mid_resets_exercised", n_midrst > 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
